// File: rtl/screen_to_hex_q16_if.sv
// Request/response bundle for the screen-to-hex picking unit.
// Both sides use valid/ready handshakes.
interface screen_to_hex_q16_if;
  logic               valid_in;
  logic               in_ready;
  logic signed [31:0] screen_x_q16;
  logic signed [31:0] screen_y_q16;
  logic               pointy_top;
  logic signed [31:0] inv_zoom_q16;
  logic signed [31:0] inv_hex_size_q16;
  logic signed [31:0] cam_x_q16;
  logic signed [31:0] cam_y_q16;
  logic               valid_out;
  logic               out_ready;
  logic signed [31:0] q;
  logic signed [31:0] r;
  logic signed [31:0] s;

  modport master (
    output valid_in, screen_x_q16, screen_y_q16, pointy_top,
           inv_zoom_q16, inv_hex_size_q16, cam_x_q16, cam_y_q16, out_ready,
    input  in_ready, valid_out, q, r, s
  );

  modport slave (
    input  valid_in, screen_x_q16, screen_y_q16, pointy_top,
           inv_zoom_q16, inv_hex_size_q16, cam_x_q16, cam_y_q16, out_ready,
    output in_ready, valid_out, q, r, s
  );
endinterface

// File: rtl/screen_to_hex_q16.sv
// Picking unit: Q16.16 screen point -> integer cube hex coordinates (q, r, s).
// One shared 32x32 multiplier, sequenced over seven steps, then cube rounding.
module screen_to_hex_q16 (
  input  logic                 clk,
  input  logic                 reset,
  screen_to_hex_q16_if.slave   bus
);
  localparam int unsigned W      = 32;
  localparam int unsigned STEP_W = 3;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(6);

  localparam logic signed [W-1:0] SQRT3_DIV3_Q = 32'sd37837;
  localparam logic signed [W-1:0] ONE_DIV3_Q   = 32'sd21845;
  localparam logic signed [W-1:0] TWO_DIV3_Q   = 32'sd43691;
  localparam logic signed [W-1:0] HALF_Q       = 32'sd32768;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RND  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [STEP_W-1:0]    step_q, step_d;

  logic                 pointy_q, pointy_d;
  logic signed [W-1:0]  sx_q, sx_d;
  logic signed [W-1:0]  sy_q, sy_d;
  logic signed [W-1:0]  izoom_q, izoom_d;
  logic signed [W-1:0]  isize_q, isize_d;
  logic signed [W-1:0]  camx_q, camx_d;
  logic signed [W-1:0]  camy_q, camy_d;

  logic signed [W-1:0]  ux_q, ux_d;
  logic signed [W-1:0]  uy_q, uy_d;
  logic signed [W-1:0]  px_q, px_d;
  logic signed [W-1:0]  py_q, py_d;
  logic signed [W-1:0]  m4_q, m4_d;
  logic signed [W-1:0]  m5_q, m5_d;
  logic signed [W-1:0]  m6_q, m6_d;

  logic                 valid_out_q, valid_out_d;
  logic signed [W-1:0]  q_q, q_d;
  logic signed [W-1:0]  r_q, r_d;
  logic signed [W-1:0]  s_q, s_d;

  logic signed [W-1:0]  mul_a, mul_b, mul_res;
  logic signed [W-1:0]  fq, fr, fs;
  logic signed [W-1:0]  rq, rr, rs;
  logic [W-1:0]         dq, dr, ds;
  logic signed [W-1:0]  cq, cr, cs;

  function automatic logic signed [W-1:0] round_q16(input logic signed [W-1:0] f);
    return (f + HALF_Q) >>> 16;
  endfunction

  function automatic logic [W-1:0] abs_err(input logic signed [W-1:0] f,
                                           input logic signed [W-1:0] n);
    logic signed [W-1:0] d;
    d = f - (n <<< 16);
    return (d < 0) ? W'(-d) : W'(d);
  endfunction

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.valid_out = valid_out_q;
  assign bus.q         = q_q;
  assign bus.r         = r_q;
  assign bus.s         = s_q;

  // Operand select for the shared multiplier, keyed by step and layout.
  always_comb begin
    mul_a = sx_q;
    mul_b = izoom_q;
    unique case (step_q)
      STEP_W'(0): begin mul_a = sx_q;          mul_b = izoom_q; end
      STEP_W'(1): begin mul_a = sy_q;          mul_b = izoom_q; end
      STEP_W'(2): begin mul_a = ux_q + camx_q; mul_b = isize_q; end
      STEP_W'(3): begin mul_a = uy_q + camy_q; mul_b = isize_q; end
      STEP_W'(4): begin
        mul_a = px_q;
        mul_b = pointy_q ? SQRT3_DIV3_Q : TWO_DIV3_Q;
      end
      STEP_W'(5): begin
        mul_a = py_q;
        mul_b = pointy_q ? ONE_DIV3_Q : SQRT3_DIV3_Q;
      end
      STEP_W'(6): begin
        mul_a = pointy_q ? py_q : px_q;
        mul_b = pointy_q ? TWO_DIV3_Q : ONE_DIV3_Q;
      end
      default: begin mul_a = sx_q; mul_b = izoom_q; end
    endcase
    mul_res = W'((64'($signed(mul_a)) * 64'($signed(mul_b))) >>> 16);
  end

  // Fractional axial coords and cube rounding; the largest-error axis is rebuilt.
  always_comb begin
    fq = pointy_q ? (m4_q - m5_q) : m4_q;
    fr = pointy_q ? m6_q : (m5_q - m6_q);
    fs = -fq - fr;
    rq = round_q16(fq);
    rr = round_q16(fr);
    rs = round_q16(fs);
    dq = abs_err(fq, rq);
    dr = abs_err(fr, rr);
    ds = abs_err(fs, rs);
    cq = rq;
    cr = rr;
    cs = rs;
    if (dq > dr && dq > ds) begin
      cq = -rr - rs;
    end else if (dr > ds) begin
      cr = -rq - rs;
    end else begin
      cs = -rq - rr;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    pointy_d    = pointy_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    izoom_d     = izoom_q;
    isize_d     = isize_q;
    camx_d      = camx_q;
    camy_d      = camy_q;
    ux_d        = ux_q;
    uy_d        = uy_q;
    px_d        = px_q;
    py_d        = py_q;
    m4_d        = m4_q;
    m5_d        = m5_q;
    m6_d        = m6_q;
    valid_out_d = valid_out_q;
    q_d         = q_q;
    r_d         = r_q;
    s_d         = s_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.valid_in) begin
          pointy_d = bus.pointy_top;
          sx_d     = bus.screen_x_q16;
          sy_d     = bus.screen_y_q16;
          izoom_d  = bus.inv_zoom_q16;
          isize_d  = bus.inv_hex_size_q16;
          camx_d   = bus.cam_x_q16;
          camy_d   = bus.cam_y_q16;
          step_d   = '0;
          state_d  = ST_MUL;
        end
      end
      ST_MUL: begin
        unique case (step_q)
          STEP_W'(0): ux_d = mul_res;
          STEP_W'(1): uy_d = mul_res;
          STEP_W'(2): px_d = mul_res;
          STEP_W'(3): py_d = mul_res;
          STEP_W'(4): m4_d = mul_res;
          STEP_W'(5): m5_d = mul_res;
          default:    m6_d = mul_res;
        endcase
        if (step_q == LAST_STEP) begin
          step_d  = '0;
          state_d = ST_RND;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_RND: begin
        q_d         = cq;
        r_d         = cr;
        s_d         = cs;
        valid_out_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          valid_out_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      pointy_q    <= 1'b0;
      sx_q        <= '0;
      sy_q        <= '0;
      izoom_q     <= '0;
      isize_q     <= '0;
      camx_q      <= '0;
      camy_q      <= '0;
      ux_q        <= '0;
      uy_q        <= '0;
      px_q        <= '0;
      py_q        <= '0;
      m4_q        <= '0;
      m5_q        <= '0;
      m6_q        <= '0;
      valid_out_q <= 1'b0;
      q_q         <= '0;
      r_q         <= '0;
      s_q         <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      pointy_q    <= pointy_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      izoom_q     <= izoom_d;
      isize_q     <= isize_d;
      camx_q      <= camx_d;
      camy_q      <= camy_d;
      ux_q        <= ux_d;
      uy_q        <= uy_d;
      px_q        <= px_d;
      py_q        <= py_d;
      m4_q        <= m4_d;
      m5_q        <= m5_d;
      m6_q        <= m6_d;
      valid_out_q <= valid_out_d;
      q_q         <= q_d;
      r_q         <= r_d;
      s_q         <= s_d;
    end
  end
endmodule

// File: tb/tb_screen_to_hex_q16.sv
// Directed bench for screen_to_hex_q16: hand-computed picks, latency,
// backpressure, input latching and reset abort.
module tb_screen_to_hex_q16;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  screen_to_hex_q16_if bus ();

  screen_to_hex_q16 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic pointy, input logic signed [31:0] sx, sy,
                         iz, isz, cx, cy);
    bus.pointy_top       = pointy;
    bus.screen_x_q16     = sx;
    bus.screen_y_q16     = sy;
    bus.inv_zoom_q16     = iz;
    bus.inv_hex_size_q16 = isz;
    bus.cam_x_q16        = cx;
    bus.cam_y_q16        = cy;
  endtask

  // Junk on the request bus after accept; a latched transaction must ignore it.
  task automatic scramble;
    set_req(~bus.pointy_top, 32'sd777777, -32'sd555555, 32'sd12345,
            32'sd98765, 32'sd999999, -32'sd424242);
  endtask

  task automatic wait_valid(input string tag);
    int cyc;
    cyc = 0;
    while (!bus.valid_out && cyc < 30) begin
      tick();
      cyc++;
    end
    check_val({tag, "_latency"}, cyc, 8);
  endtask

  task automatic run_txn(input string tag, input logic pointy,
                         input logic signed [31:0] sx, sy, iz, isz, cx, cy,
                         input logic signed [31:0] eq, er, es);
    set_req(pointy, sx, sy, iz, isz, cx, cy);
    bus.valid_in = 1'b1;
    check_val({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    tick();
    bus.valid_in = 1'b0;
    scramble();
    wait_valid(tag);
    check_val({tag, "_q"}, bus.q, eq);
    check_val({tag, "_r"}, bus.r, er);
    check_val({tag, "_s"}, bus.s, es);
    check_val({tag, "_busy"}, 32'(bus.in_ready), 0);
    tick();
    check_val({tag, "_vo_drop"}, 32'(bus.valid_out), 0);
    check_val({tag, "_idle"}, 32'(bus.in_ready), 1);
  endtask

  initial begin
    bit held_ok;
    reset         = 1'b1;
    bus.valid_in  = 1'b0;
    bus.out_ready = 1'b1;
    set_req(1'b1, 0, 0, 32'sd65536, 32'sd65536, 0, 0);
    repeat (3) tick();
    check_val("rst_in_ready", 32'(bus.in_ready), 1);
    check_val("rst_valid_out", 32'(bus.valid_out), 0);
    check_val("rst_q", bus.q, 0);
    check_val("rst_r", bus.r, 0);
    check_val("rst_s", bus.s, 0);
    reset = 1'b0;
    tick();

    run_txn("origin", 1'b1, 0, 0, 32'sd65536, 32'sd65536, 0, 0, 0, 0, 0);
    run_txn("pt_pos", 1'b1, 32'sd113512, 0, 32'sd65536, 32'sd65536, 0, 0, 1, 0, -1);
    run_txn("pt_neg", 1'b1, -32'sd113512, 0, 32'sd65536, 32'sd65536, 0, 0, -1, 0, 1);
    run_txn("flat", 1'b0, 32'sd98304, 0, 32'sd65536, 32'sd65536, 0, 0, 1, 0, -1);
    run_txn("pt_y", 1'b1, 0, 32'sd98304, 32'sd65536, 32'sd65536, 0, 0, 0, 1, -1);
    run_txn("cam", 1'b1, 0, 0, 32'sd32768, 32'sd65536, 32'sd113512, 0, 1, 0, -1);
    run_txn("size2", 1'b1, 32'sd227024, 0, 32'sd65536, 32'sd32768, 0, 0, 1, 0, -1);

    // Backpressure: hold out_ready low for 5 cycles with valid_in pulses.
    set_req(1'b1, 32'sd113512, 0, 32'sd65536, 32'sd65536, 0, 0);
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in  = 1'b0;
    bus.out_ready = 1'b0;
    scramble();
    wait_valid("bp");
    for (int k = 0; k < 5; k++) begin
      bus.valid_in = k[0];
      tick();
      check_val("bp_valid_hold", 32'(bus.valid_out), 1);
      check_val("bp_q_hold", bus.q, 1);
      check_val("bp_r_hold", bus.r, 0);
      check_val("bp_s_hold", bus.s, -1);
      check_val("bp_in_ready", 32'(bus.in_ready), 0);
    end
    bus.valid_in  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check_val("bp_release_vo", 32'(bus.valid_out), 0);
    check_val("bp_release_idle", 32'(bus.in_ready), 1);
    run_txn("after_bp", 1'b1, -32'sd113512, 0, 32'sd65536, 32'sd65536, 0, 0, -1, 0, 1);

    // Reset on the accept edge: request must be dropped.
    set_req(1'b1, 32'sd113512, 0, 32'sd65536, 32'sd65536, 0, 0);
    bus.valid_in = 1'b1;
    reset        = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    reset        = 1'b0;
    check_val("rst_acc_idle", 32'(bus.in_ready), 1);
    held_ok = 1'b1;
    repeat (12) begin
      tick();
      if (bus.valid_out !== 1'b0 || bus.in_ready !== 1'b1) held_ok = 1'b0;
    end
    check_val("rst_acc_no_result", 32'(held_ok), 1);

    // Put a nonzero result on the outputs, then abort a request in MUL step 3.
    run_txn("pre_abort", 1'b1, 32'sd113512, 0, 32'sd65536, 32'sd65536, 0, 0, 1, 0, -1);
    set_req(1'b1, 32'sd113512, 0, 32'sd65536, 32'sd65536, 0, 0);
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("abort_vo", 32'(bus.valid_out), 0);
    check_val("abort_in_ready", 32'(bus.in_ready), 1);
    check_val("abort_q", bus.q, 0);
    check_val("abort_r", bus.r, 0);
    check_val("abort_s", bus.s, 0);
    held_ok = 1'b1;
    repeat (12) begin
      tick();
      if (bus.valid_out !== 1'b0) held_ok = 1'b0;
    end
    check_val("abort_no_result", 32'(held_ok), 1);
    run_txn("post_abort", 1'b0, 32'sd98304, 0, 32'sd65536, 32'sd65536, 0, 0, 1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
